router_terminal_endpoint: RTL and testbench

//  Device-side endpoint for one terminal of router_bus_gnrtr.

---
 rtl/router_terminal_endpoint.sv | 207 ++++++++++++++++++++
 tb/tb_router_terminal_endpoint.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_terminal_endpoint.sv
// -----------------------------------------------------------------------------
// router_terminal_endpoint
//
// Device-side endpoint for one terminal of router_bus_gnrtr.
//   Source side: local packets are buffered in a first-word-fall-through TX
//   FIFO whose head is presented to the router. The router retires the head
//   by pulsing popin.
//   Sink side: a three-state FSM drains the router output with a registered
//   pop pulse (at most one packet every 3 cycles). It keeps packets whose
//   destination ID matches term_id or broadcast, stores them in an RX FIFO
//   and counts packets addressed elsewhere.
//
// Ports
//   clk            clock, all logic on posedge
//   reset          synchronous active-low reset
//   tx_data        local packet to send
//   tx_push        write tx_data into the TX FIFO
//   tx_full        TX FIFO full
//   tx_drop        sticky flag: a push arrived while the TX FIFO was full
//   data_out_i_in  TX FIFO head, presented to the router
//   pndng_i_in     TX FIFO not empty
//   popin          router consumes the TX head this cycle
//   data_out       packet that the router presents to this terminal
//   pndng          router has a packet pending
//   pop            consume the router packet (registered pulse)
//   rx_data        RX FIFO head
//   rx_valid       RX FIFO not empty
//   rx_pop         local logic consumes rx_data
//   misroute_cnt   saturating count of popped packets with a foreign ID
//   rx_cnt         saturating count of packets accepted into the RX FIFO
// -----------------------------------------------------------------------------
module router_terminal_endpoint #(
  parameter int unsigned pckg_sz    = 32,
  parameter int unsigned fifo_depth = 16,
  parameter logic [7:0]  term_id    = 8'd0,
  parameter logic [7:0]  broadcast  = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [pckg_sz-1:0] tx_data,
  input  logic               tx_push,
  output logic               tx_full,
  output logic               tx_drop,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin,
  input  logic [pckg_sz-1:0] data_out,
  input  logic               pndng,
  output logic               pop,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_pop,
  output logic [15:0]        misroute_cnt,
  output logic [15:0]        rx_cnt
);

  localparam int unsigned    AW         = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned    CW         = AW + 1;
  localparam logic [CW-1:0]  LP_DEPTH   = CW'(fifo_depth);
  localparam logic [CW-1:0]  LP_CNT_ONE = CW'(1);
  localparam logic [AW-1:0]  LP_PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_GAP
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [pckg_sz-1:0] r_tx_mem [fifo_depth];
  logic [AW-1:0]      r_tx_wr_ptr;
  logic [AW-1:0]      r_tx_rd_ptr;
  logic [CW-1:0]      r_tx_count;
  logic               r_tx_drop;
  logic               w_tx_full;
  logic               w_tx_wr;
  logic               w_tx_rd;

  // Fullness is judged on the registered count, so a same-cycle popin does
  // not make room for a push.
  assign w_tx_full = (r_tx_count == LP_DEPTH);
  assign w_tx_wr   = tx_push && !w_tx_full;
  assign w_tx_rd   = popin && (r_tx_count != '0);

  // NOTE: the storage arrays have no reset. The pointers and counts decide
  // which entries are valid, and arrays without reset can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_tx_wr) r_tx_mem[r_tx_wr_ptr] <= tx_data;
  end

  // NOTE: clocked blocks use only non-blocking assignments. Every register
  // then computes its next value from the state that existed before the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_wr_ptr <= '0;
      r_tx_rd_ptr <= '0;
      r_tx_count  <= '0;
      r_tx_drop   <= 1'b0;
    end else begin
      if (w_tx_wr) r_tx_wr_ptr <= r_tx_wr_ptr + LP_PTR_ONE;
      if (w_tx_rd) r_tx_rd_ptr <= r_tx_rd_ptr + LP_PTR_ONE;
      case ({w_tx_wr, w_tx_rd})
        2'b10:   r_tx_count <= r_tx_count + LP_CNT_ONE;
        2'b01:   r_tx_count <= r_tx_count - LP_CNT_ONE;
        default: r_tx_count <= r_tx_count;
      endcase
      if (tx_push && w_tx_full) r_tx_drop <= 1'b1;
    end
  end

  assign tx_full       = w_tx_full;
  assign tx_drop       = r_tx_drop;
  assign pndng_i_in    = (r_tx_count != '0);
  assign data_out_i_in = r_tx_mem[r_tx_rd_ptr];

  // ---------------------------------------------------------------------------
  // RX FSM and destination filter
  // ---------------------------------------------------------------------------
  rx_state_e          r_state;
  logic               r_pop;
  logic [15:0]        r_rx_acc_cnt;
  logic [15:0]        r_misroute_cnt;
  logic [CW-1:0]      r_rx_count;
  logic [7:0]         w_dst;
  logic               w_dst_match;
  logic               w_rx_wr;

  assign w_dst       = data_out[pckg_sz-1 -: 8];
  assign w_dst_match = (w_dst == term_id) || (w_dst == broadcast);
  // The packet is sampled on the edge that ends POP. A reset on that edge
  // discards the packet.
  assign w_rx_wr     = reset && (r_state == ST_POP) && w_dst_match;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_pop          <= 1'b0;
      r_rx_acc_cnt   <= '0;
      r_misroute_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // The registered count guarantees room for the packet popped next.
          if (pndng && (r_rx_count < LP_DEPTH)) begin
            r_state <= ST_POP;
            r_pop   <= 1'b1;
          end
        end
        ST_POP: begin
          r_state <= ST_GAP;
          r_pop   <= 1'b0;
          if (w_dst_match) begin
            if (r_rx_acc_cnt != 16'hFFFF) r_rx_acc_cnt <= r_rx_acc_cnt + 16'd1;
          end else begin
            if (r_misroute_cnt != 16'hFFFF) r_misroute_cnt <= r_misroute_cnt + 16'd1;
          end
        end
        // GAP holds pop low for one cycle so that the router can update pndng.
        ST_GAP: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_pop   <= 1'b0;
        end
      endcase
    end
  end

  assign pop          = r_pop;
  assign rx_cnt       = r_rx_acc_cnt;
  assign misroute_cnt = r_misroute_cnt;

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [pckg_sz-1:0] r_rx_mem [fifo_depth];
  logic [AW-1:0]      r_rx_wr_ptr;
  logic [AW-1:0]      r_rx_rd_ptr;
  logic               w_rx_rd;

  assign w_rx_rd = rx_pop && (r_rx_count != '0);

  always_ff @(posedge clk) begin
    if (w_rx_wr) r_rx_mem[r_rx_wr_ptr] <= data_out;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_wr_ptr <= '0;
      r_rx_rd_ptr <= '0;
      r_rx_count  <= '0;
    end else begin
      if (w_rx_wr) r_rx_wr_ptr <= r_rx_wr_ptr + LP_PTR_ONE;
      if (w_rx_rd) r_rx_rd_ptr <= r_rx_rd_ptr + LP_PTR_ONE;
      case ({w_rx_wr, w_rx_rd})
        2'b10:   r_rx_count <= r_rx_count + LP_CNT_ONE;
        2'b01:   r_rx_count <= r_rx_count - LP_CNT_ONE;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  assign rx_valid = (r_rx_count != '0);
  assign rx_data  = r_rx_mem[r_rx_rd_ptr];

endmodule

// File: tb/tb_router_terminal_endpoint.sv
// -----------------------------------------------------------------------------
// tb_router_terminal_endpoint
//
// Self-checking bench for router_terminal_endpoint with term_id = 3.
//   - A router model feeds queued packets on data_out/pndng. It drops the head
//     packet when pop is high at a clock edge.
//   - Queues exp_tx and exp_rx hold the expected TX and RX packets in order.
//   - A monitor counts pop pulses and records any two pulses that come less
//     than 3 cycles apart.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at the
// same point.
// -----------------------------------------------------------------------------
module tb_router_terminal_endpoint;

  localparam int PW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] tx_data;
  logic          tx_push;
  logic          tx_full;
  logic          tx_drop;
  logic [PW-1:0] data_out_i_in;
  logic          pndng_i_in;
  logic          popin;
  logic [PW-1:0] data_out;
  logic          pndng;
  logic          pop;
  logic [PW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_pop;
  logic [15:0]   misroute_cnt;
  logic [15:0]   rx_cnt;

  always #5 clk = ~clk;

  router_terminal_endpoint #(
    .pckg_sz   (PW),
    .fifo_depth(DEPTH),
    .term_id   (8'h03),
    .broadcast (8'hFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_push      (tx_push),
    .tx_full      (tx_full),
    .tx_drop      (tx_drop),
    .data_out_i_in(data_out_i_in),
    .pndng_i_in   (pndng_i_in),
    .popin        (popin),
    .data_out     (data_out),
    .pndng        (pndng),
    .pop          (pop),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_pop       (rx_pop),
    .misroute_cnt (misroute_cnt),
    .rx_cnt       (rx_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] router_q [$];
  logic [PW-1:0] exp_tx   [$];
  logic [PW-1:0] exp_rx   [$];

  int cyc          = 0;
  int last_pop_cyc = -100;
  int pop_total    = 0;
  int gap_err      = 0;

  // Router model: pop at an edge removes the presented packet. Outputs update
  // on the falling edge, so they are stable at the next rising edge.
  always @(posedge clk) begin
    cyc++;
    if (pop === 1'b1) begin
      pop_total++;
      if (cyc - last_pop_cyc < 3) gap_err++;
      last_pop_cyc = cyc;
      if (router_q.size() != 0) void'(router_q.pop_front());
    end
  end

  always @(negedge clk) begin
    pndng    = (router_q.size() != 0);
    data_out = (router_q.size() != 0) ? router_q[0] : '0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_rx(input int budget);
    int b;
    b = budget;
    while (exp_rx.size() != 0 && b > 0) begin
      if (rx_valid === 1'b1) begin
        logic [PW-1:0] e;
        e = exp_rx.pop_front();
        n_checks++;
        if (rx_data !== e) begin
          n_fail++;
          $display("FAIL rx_data_order: got %h want %h", rx_data, e);
        end
        rx_pop = 1'b1;
      end else begin
        rx_pop = 1'b0;
      end
      step();
      b--;
    end
    rx_pop = 1'b0;
    n_checks++;
    if (exp_rx.size() != 0) begin
      n_fail++;
      $display("FAIL rx_drain_timeout: got %0d left want 0", exp_rx.size());
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    tx_push = 1'b1;
    tx_data = 32'h1111_1111;
    router_q.push_back(32'h0300_0001);
    repeat (3) step();
    n_checks++; if (pop !== 1'b0)        begin n_fail++; $display("FAIL reset_pop: got %b want 0", pop); end
    n_checks++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL reset_pndng_i_in: got %b want 0", pndng_i_in); end
    n_checks++; if (tx_full !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
    n_checks++; if (tx_drop !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_drop: got %b want 0", tx_drop); end
    n_checks++; if (rx_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (rx_cnt !== 16'd0)    begin n_fail++; $display("FAIL reset_rx_cnt: got %0d want 0", rx_cnt); end
    n_checks++; if (misroute_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_misroute: got %0d want 0", misroute_cnt); end
    tx_push = 1'b0;
    router_q.delete();
    reset = 1'b1;
    step();
    n_checks++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL reset_release_pndng_i_in: got %b want 0", pndng_i_in); end
  endtask

  task automatic test_tx();
    // A popin while the FIFO is empty must not move the pointers.
    popin = 1'b1;
    step();
    popin = 1'b0;
    n_checks++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL tx_empty_popin: got %b want 0", pndng_i_in); end
    for (int i = 1; i <= 3; i++) begin
      tx_data = 32'hA500_0000 + PW'(i);
      tx_push = 1'b1;
      exp_tx.push_back(tx_data);
      step();
      tx_push = 1'b0;
      if (i == 1) begin
        n_checks++; if (pndng_i_in !== 1'b1) begin n_fail++; $display("FAIL tx_pndng_after_write: got %b want 1", pndng_i_in); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      logic [PW-1:0] e;
      e = exp_tx.pop_front();
      n_checks++; if (data_out_i_in !== e) begin n_fail++; $display("FAIL tx_order: got %h want %h", data_out_i_in, e); end
      popin = 1'b1;
      step();
      popin = 1'b0;
    end
    n_checks++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL tx_empty_after_3: got %b want 0", pndng_i_in); end
  endtask

  task automatic test_tx_full();
    logic [PW-1:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      tx_data = 32'hB000_0000 + PW'(i);
      tx_push = 1'b1;
      exp_tx.push_back(tx_data);
      step();
      n_checks++; if (tx_full !== (i == DEPTH - 1)) begin n_fail++; $display("FAIL tx_full_fill_%0d: got %b want %b", i, tx_full, (i == DEPTH - 1)); end
    end
    n_checks++; if (tx_drop !== 1'b0) begin n_fail++; $display("FAIL tx_drop_early: got %b want 0", tx_drop); end
    tx_data = 32'hDEAD_0017;
    step();
    tx_push = 1'b0;
    n_checks++; if (tx_drop !== 1'b1) begin n_fail++; $display("FAIL tx_drop_set: got %b want 1", tx_drop); end
    n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL tx_full_hold: got %b want 1", tx_full); end
    // Push and popin together while full: the push is dropped and the pop retires the head.
    tx_data = 32'hBEEF_0000;
    tx_push = 1'b1;
    popin   = 1'b1;
    e = exp_tx.pop_front();
    n_checks++; if (data_out_i_in !== e) begin n_fail++; $display("FAIL tx_full_head: got %h want %h", data_out_i_in, e); end
    step();
    tx_push = 1'b0;
    popin   = 1'b0;
    n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL tx_full_after_popin: got %b want 0", tx_full); end
    // Push and popin together while not full: the count stays the same.
    tx_data = 32'hC100_0001;
    tx_push = 1'b1;
    popin   = 1'b1;
    e = exp_tx.pop_front();
    n_checks++; if (data_out_i_in !== e) begin n_fail++; $display("FAIL tx_simul_head: got %h want %h", data_out_i_in, e); end
    exp_tx.push_back(tx_data);
    step();
    popin = 1'b0;
    n_checks++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL tx_simul_count: got %b want 0", tx_full); end
    tx_data = 32'hC200_0002;
    exp_tx.push_back(tx_data);
    step();
    tx_push = 1'b0;
    n_checks++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL tx_refill_full: got %b want 1", tx_full); end
    while (exp_tx.size() != 0) begin
      e = exp_tx.pop_front();
      n_checks++; if (data_out_i_in !== e) begin n_fail++; $display("FAIL tx_wrap_order: got %h want %h", data_out_i_in, e); end
      popin = 1'b1;
      step();
      popin = 1'b0;
    end
    n_checks++; if (pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL tx_drained: got %b want 0", pndng_i_in); end
    n_checks++; if (tx_drop !== 1'b1)    begin n_fail++; $display("FAIL tx_drop_sticky: got %b want 1", tx_drop); end
  endtask

  task automatic test_rx_filter();
    router_q.push_back(32'h0300_0011);
    router_q.push_back(32'hFF00_0022);
    router_q.push_back(32'h0500_0033);
    exp_rx.push_back(32'h0300_0011);
    exp_rx.push_back(32'hFF00_0022);
    for (int i = 0; i < 60 && router_q.size() != 0; i++) step();
    repeat (4) step();
    n_checks++; if (router_q.size() != 0) begin n_fail++; $display("FAIL rx_filter_timeout: got %0d left want 0", router_q.size()); end
    n_checks++; if (rx_cnt !== 16'd2)       begin n_fail++; $display("FAIL rx_filter_rx_cnt: got %0d want 2", rx_cnt); end
    n_checks++; if (misroute_cnt !== 16'd1) begin n_fail++; $display("FAIL rx_filter_misroute: got %0d want 1", misroute_cnt); end
    n_checks++; if (gap_err != 0)           begin n_fail++; $display("FAIL rx_filter_pop_spacing: got %0d violations want 0", gap_err); end
    drain_rx(20);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_filter_empty: got %b want 0", rx_valid); end
    // An rx_pop while the RX FIFO is empty must be ignored.
    rx_pop = 1'b1;
    step();
    rx_pop = 1'b0;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_empty_pop: got %b want 0", rx_valid); end
  endtask

  task automatic test_rx_backpressure();
    int p0;
    rx_pop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      router_q.push_back(32'h0300_0040 + PW'(i));
      exp_rx.push_back(32'h0300_0040 + PW'(i));
    end
    repeat (80) step();
    n_checks++; if (rx_cnt !== 16'd18)        begin n_fail++; $display("FAIL bp_stored: got %0d want 18", rx_cnt); end
    n_checks++; if (router_q.size() != 4)     begin n_fail++; $display("FAIL bp_router_left: got %0d want 4", router_q.size()); end
    p0 = pop_total;
    repeat (10) step();
    n_checks++; if (pop_total != p0)          begin n_fail++; $display("FAIL bp_pop_while_full: got %0d pops want 0", pop_total - p0); end
    begin
      logic [PW-1:0] e;
      e = exp_rx.pop_front();
      n_checks++; if (rx_data !== e) begin n_fail++; $display("FAIL bp_head: got %h want %h", rx_data, e); end
    end
    rx_pop = 1'b1;
    step();
    rx_pop = 1'b0;
    repeat (10) step();
    n_checks++; if (pop_total != p0 + 1)      begin n_fail++; $display("FAIL bp_one_more_pop: got %0d pops want 1", pop_total - p0); end
    n_checks++; if (rx_cnt !== 16'd19)        begin n_fail++; $display("FAIL bp_rx_cnt_19: got %0d want 19", rx_cnt); end
    drain_rx(200);
    repeat (4) step();
    n_checks++; if (rx_cnt !== 16'd22)        begin n_fail++; $display("FAIL bp_rx_cnt_final: got %0d want 22", rx_cnt); end
    n_checks++; if (misroute_cnt !== 16'd1)   begin n_fail++; $display("FAIL bp_misroute: got %0d want 1", misroute_cnt); end
    n_checks++; if (rx_valid !== 1'b0)        begin n_fail++; $display("FAIL bp_rx_empty: got %b want 0", rx_valid); end
    n_checks++; if (gap_err != 0)             begin n_fail++; $display("FAIL bp_pop_spacing: got %0d violations want 0", gap_err); end
  endtask

  task automatic test_reset_mid_pop();
    bit seen;
    seen = 1'b0;
    router_q.push_back(32'h0300_0009);
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (pop === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_pop_timeout: got no pop want pop"); end
    reset = 1'b0;
    step();
    n_checks++; if (pop !== 1'b0)      begin n_fail++; $display("FAIL mid_pop_pop: got %b want 0", pop); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_pop_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (rx_cnt !== 16'd0)  begin n_fail++; $display("FAIL mid_pop_rx_cnt: got %0d want 0", rx_cnt); end
    router_q.delete();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_pop_after_release: got %b want 0", rx_valid); end
    n_checks++; if (pop !== 1'b0)      begin n_fail++; $display("FAIL mid_pop_no_repop: got %b want 0", pop); end
  endtask

  initial begin
    reset   = 1'b0;
    tx_data = '0;
    tx_push = 1'b0;
    popin   = 1'b0;
    rx_pop  = 1'b0;
    test_reset();
    test_tx();
    test_tx_full();
    test_rx_filter();
    test_rx_backpressure();
    test_reset_mid_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule
